fifo_stream_reader: RTL and testbench

Read-side engine for the synchronous FIFO. It watches the FIFO's `empty` flag, issues `rd_en`, and captures `dout` one cycle after each read. Captured words are presented downstream on a valid/ready stream through a 2-entry output buffer, which sustains one word per cycle under continuous `m_ready`. It sits between the FIFO read port and any consumer, and is the counterpart of the write-side agent driving `wr_en`/`din`.

---
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side engine for the synchronous FIFO.
// Issues rd_en under a credit rule, captures dout one cycle after each read,
// and presents the captured words on a valid/ready stream through a
// 2-entry buffer so that one word per cycle flows under continuous ready.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_dout,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic [CNT_WIDTH-1:0]  o_rd_count,
    output logic                  o_busy
);

    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic                  r_head;
    logic                  r_tail;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic [CNT_WIDTH-1:0]  r_rd_count;

    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_credit;

    // Pop happens on the stream handshake; the level is what occupancy will be
    // after this cycle, counting the word already in flight from the FIFO.
    // A read may only be issued while that level leaves room for its word.
    assign w_pop        = o_m_valid & i_m_ready;
    assign w_level      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit     = (w_level < 3'd2);
    assign o_fifo_rd_en = i_enable & ~i_fifo_empty & w_credit;

    assign o_m_valid  = (r_occ != 2'd0);
    assign o_m_data   = r_buf[r_head];
    assign o_rd_count = r_rd_count;
    assign o_busy     = r_inflight | (r_occ != 2'd0);

    // Remember that a read was issued so its data is captured next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_fifo_rd_en;
        end
    end

    // Occupancy and ring pointers; capture and pop in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_head <= 1'b0;
            r_tail <= 1'b0;
        end else begin
            r_occ <= w_level[1:0];
            if (r_inflight) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    // Buffer storage: the in-flight word lands at the tail slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_buf[i] <= '0;
            end
        end else if (r_inflight) begin
            r_buf[r_tail] <= i_fifo_dout;
        end
    end

    // Count every issued read, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
        end else if (o_fifo_rd_en) begin
            r_rd_count <= r_rd_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: drives fifo_stream_reader from a behavioural FIFO
// model and checks directed scenarios plus a randomized run against a
// queue-based reference of what has been read and what has been consumed.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fifoEmpty;
    logic        rdEn;
    logic [7:0]  fifoDout;
    logic        mValid;
    logic        mReady;
    logic [7:0]  mData;
    logic [15:0] rdCount;
    logic        busy;

    logic        pushValid;
    logic [7:0]  pushWord;

    logic [7:0]  fifoQ[$];
    logic [7:0]  readLog[$];
    logic        inflightM;
    logic [15:0] readCount;

    int compared   = 0;
    int mismatched = 0;
    int gotIdx     = 0;

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (enable),
        .i_fifo_empty(fifoEmpty),
        .o_fifo_rd_en(rdEn),
        .i_fifo_dout (fifoDout),
        .o_m_valid   (mValid),
        .i_m_ready   (mReady),
        .o_m_data    (mData),
        .o_rd_count  (rdCount),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: one write and one registered read per clock edge,
    // logging every word handed out so the stream can be checked against it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifoQ.delete();
            readLog.delete();
            fifoDout  <= 8'h00;
            fifoEmpty <= 1'b1;
            inflightM <= 1'b0;
            readCount <= 16'd0;
        end else begin
            inflightM <= rdEn;
            if (rdEn && fifoQ.size() != 0) begin
                fifoDout <= fifoQ[0];
                readLog.push_back(fifoQ[0]);
                void'(fifoQ.pop_front());
                readCount <= readCount + 16'd1;
            end
            if (pushValid) begin
                fifoQ.push_back(pushWord);
            end
            fifoEmpty <= (fifoQ.size() == 0);
        end
    end

    task automatic loadWord(input logic [7:0] w);
        @(negedge clk);
        pushValid = 1'b1;
        pushWord  = w;
        @(posedge clk);
        #1;
        pushValid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        mReady = 1'b0;
        pushValid = 1'b0;
        pushWord = 8'h00;
        repeat (2) @(negedge clk);
        #3;
        if ({rdEn, mValid, busy} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {rdEn, mValid, busy}); end
        compared++;
        if (mData !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data: got %0h expected 0", mData); end
        compared++;
        if (rdCount !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", rdCount); end
        compared++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #3;
            if ({rdEn, mValid, busy} !== 3'b000 || rdCount !== 16'd0) begin
                mismatched++;
                $display("[TB] FAIL idle_c%0d: got rd/v/b=%b cnt=%0d expected 000 cnt=0", c, {rdEn, mValid, busy}, rdCount);
            end
            compared++;
        end
    endtask

    task automatic test_single();
        logic [15:0] base;
        mReady = 1'b1;
        loadWord(8'hA5);
        base = readCount;
        @(negedge clk);
        enable = 1'b1;
        #3;
        if (rdEn !== 1'b1) begin mismatched++; $display("[TB] FAIL single_rd_c0: got %b expected 1", rdEn); end
        compared++;
        @(negedge clk);
        #3;
        if ({rdEn, mValid} !== 2'b00) begin mismatched++; $display("[TB] FAIL single_c1: got rd/v=%b expected 00", {rdEn, mValid}); end
        compared++;
        @(negedge clk);
        #3;
        if (mValid !== 1'b1 || mData !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_word_c2: got v=%b d=%0h expected v=1 d=a5", mValid, mData); end
        compared++;
        @(negedge clk);
        #3;
        if ({busy, mValid} !== 2'b00 || rdCount !== base + 16'd1) begin
            mismatched++;
            $display("[TB] FAIL single_c3: got b/v=%b cnt=%0d expected 00 cnt=%0d", {busy, mValid}, rdCount, base + 16'd1);
        end
        compared++;
        enable = 1'b0;
    endtask

    task automatic test_streaming();
        logic [15:0] base;
        logic        expRd;
        logic        expV;
        mReady = 1'b1;
        for (int i = 1; i <= 16; i++) loadWord(8'(i));
        base = readCount;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (c == 0) enable = 1'b1;
            #3;
            expRd = (c < 16);
            expV  = (c >= 2 && c < 18);
            if (rdEn !== expRd) begin mismatched++; $display("[TB] FAIL stream_rd_c%0d: got %b expected %b", c, rdEn, expRd); end
            compared++;
            if (mValid !== expV || (expV && mData !== 8'(c - 1))) begin
                mismatched++;
                $display("[TB] FAIL stream_out_c%0d: got v=%b d=%0h expected v=%b d=%0h", c, mValid, mData, expV, 8'(c - 1));
            end
            compared++;
        end
        if (rdCount !== base + 16'd16) begin mismatched++; $display("[TB] FAIL stream_count: got %0d expected %0d", rdCount, base + 16'd16); end
        compared++;
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        int pulses;
        pulses = 0;
        mReady = 1'b0;
        for (int i = 1; i <= 8; i++) loadWord(8'(i));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) enable = 1'b1;
            #3;
            if (rdEn === 1'b1) pulses++;
            if (c >= 2) begin
                if (mValid !== 1'b1 || mData !== 8'h01) begin mismatched++; $display("[TB] FAIL bp_hold_c%0d: got v=%b d=%0h expected v=1 d=1", c, mValid, mData); end
                compared++;
            end
        end
        if (pulses != 2) begin mismatched++; $display("[TB] FAIL bp_pulses: got %0d expected 2", pulses); end
        compared++;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) mReady = 1'b1;
            #3;
            if (mValid !== 1'b1 || mData !== 8'(c + 1)) begin mismatched++; $display("[TB] FAIL bp_drain_c%0d: got v=%b d=%0h expected v=1 d=%0h", c, mValid, mData, 8'(c + 1)); end
            compared++;
        end
        @(negedge clk);
        #3;
        if ({busy, mValid} !== 2'b00) begin mismatched++; $display("[TB] FAIL bp_idle: got b/v=%b expected 00", {busy, mValid}); end
        compared++;
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [15:0] base;
        mReady = 1'b1;
        loadWord(8'h3C);
        loadWord(8'hC3);
        base = readCount;
        @(negedge clk);
        enable = 1'b1;
        #3;
        if (rdEn !== 1'b1) begin mismatched++; $display("[TB] FAIL endrop_rd_c0: got %b expected 1", rdEn); end
        compared++;
        @(negedge clk);
        enable = 1'b0;
        for (int c = 1; c < 7; c++) begin
            if (c > 1) @(negedge clk);
            #3;
            if (rdEn !== 1'b0) begin mismatched++; $display("[TB] FAIL endrop_rd_c%0d: got %b expected 0", c, rdEn); end
            compared++;
            if (c == 2 && (mValid !== 1'b1 || mData !== 8'h3C)) begin mismatched++; $display("[TB] FAIL endrop_word: got v=%b d=%0h expected v=1 d=3c", mValid, mData); end
            if (c == 2) compared++;
            if (c > 2 && mValid !== 1'b0) begin mismatched++; $display("[TB] FAIL endrop_extra_c%0d: got v=%b expected 0", c, mValid); end
            if (c > 2) compared++;
        end
        if (rdCount !== base + 16'd1) begin mismatched++; $display("[TB] FAIL endrop_count: got %0d expected %0d", rdCount, base + 16'd1); end
        compared++;
    endtask

    task automatic test_async_reset();
        logic [7:0] expW [2];
        int got;
        expW[0] = 8'h55;
        expW[1] = 8'h66;
        got = 0;
        mReady = 1'b0;
        loadWord(8'h11);
        loadWord(8'h22);
        loadWord(8'h33);
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        if ({mValid, busy} !== 2'b11) begin mismatched++; $display("[TB] FAIL arst_pre: got v/b=%b expected 11", {mValid, busy}); end
        compared++;
        rst_n = 1'b0;
        #1;
        if ({rdEn, mValid, busy} !== 3'b000 || mData !== 8'h00 || rdCount !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL arst_outputs: got rd/v/b=%b d=%0h cnt=%0d expected 000 d=0 cnt=0", {rdEn, mValid, busy}, mData, rdCount);
        end
        compared++;
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mReady = 1'b1;
        loadWord(8'h55);
        loadWord(8'h66);
        @(negedge clk);
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #3;
            if (mValid === 1'b1) begin
                if (got >= 2 || mData !== expW[got > 1 ? 1 : got]) begin
                    mismatched++;
                    $display("[TB] FAIL arst_fresh_%0d: got %0h expected %0h", got, mData, expW[got > 1 ? 1 : got]);
                end
                compared++;
                got++;
            end
        end
        if (got != 2 || rdCount !== 16'd2) begin mismatched++; $display("[TB] FAIL arst_total: got words=%0d cnt=%0d expected words=2 cnt=2", got, rdCount); end
        compared++;
        enable = 1'b0;
        gotIdx = got;
    endtask

    task automatic test_random();
        int         outstanding;
        logic       expV;
        logic       expRd;
        logic       popM;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (c < 600) begin
                pushValid = 1'($urandom % 2);
                pushWord  = 8'($urandom);
                enable    = ($urandom % 4) != 0;
                mReady    = ($urandom % 3) != 0;
            end else begin
                pushValid = 1'b0;
                enable    = 1'b1;
                mReady    = 1'b1;
            end
            #3;
            outstanding = readLog.size() - gotIdx;
            expV  = (outstanding - int'(inflightM)) > 0;
            popM  = expV && mReady;
            expRd = enable && !fifoEmpty && ((outstanding - int'(popM)) < 2);
            if (mValid !== expV || busy !== (outstanding > 0)) begin
                mismatched++;
                $display("[TB] FAIL rand_flags_c%0d: got v/b=%b%b expected %b%b", c, mValid, busy, expV, outstanding > 0);
            end
            compared++;
            if (rdEn !== expRd) begin mismatched++; $display("[TB] FAIL rand_rd_c%0d: got %b expected %b", c, rdEn, expRd); end
            compared++;
            if (rdCount !== readCount) begin mismatched++; $display("[TB] FAIL rand_count_c%0d: got %0d expected %0d", c, rdCount, readCount); end
            compared++;
            if (mValid === 1'b1 && mReady === 1'b1 && gotIdx < readLog.size()) begin
                if (mData !== readLog[gotIdx]) begin mismatched++; $display("[TB] FAIL rand_data_%0d: got %0h expected %0h", gotIdx, mData, readLog[gotIdx]); end
                compared++;
                gotIdx++;
            end
        end
        if (busy !== 1'b0 || fifoEmpty !== 1'b1 || gotIdx != readLog.size()) begin
            mismatched++;
            $display("[TB] FAIL rand_drain: got busy=%b empty=%b consumed=%0d expected busy=0 empty=1 consumed=%0d", busy, fifoEmpty, gotIdx, readLog.size());
        end
        compared++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
